// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Feeds per-digit 7-segment decoders: bcd_o/ovf_o change only when a
// conversion completes (or on reset), so the decoders never see partial
// scratch values.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [BIN_W-1:0]      bin_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  ovf_o,
    output logic [4*DIGITS-1:0]   bcd_o
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    // Largest value representable in DIGITS decimal digits.
    function automatic logic [63:0] max_dec();
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < DIGITS; i++) p = p * 64'd10;
        return p - 64'd1;
    endfunction

    localparam logic [63:0] MAX_DEC = max_dec();
    // If every BIN_W-bit value fits in DIGITS digits, overflow is impossible
    // and the truncated compare constant below must not be used.
    localparam bit OVF_EN = (BIN_W < 64) && (MAX_DEC < (64'd1 << BIN_W));
    localparam logic [BIN_W-1:0] MAX_BIN = MAX_DEC[BIN_W-1:0];

    typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [BCD_W-1:0]   scr_q, scr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    logic [BCD_W-1:0]   scr_adj;
    logic [BCD_W-1:0]   scr_shift;

    // Add-3 correction per digit: any nibble >= 5 would exceed 9 after doubling.
    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        assign scr_adj[4*g +: 4] = (scr_q[4*g +: 4] >= 4'd5) ? scr_q[4*g +: 4] + 4'd3
                                                             : scr_q[4*g +: 4];
    end

    // Corrected scratch shifted left, taking the next binary MSB into bit 0.
    assign scr_shift = {scr_adj[BCD_W-2:0], shift_q[BIN_W-1]};

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            scr_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scr_q      <= scr_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    // Next-state: accept in IDLE, shift one bit per cycle in CONV, publish
    // the result on the edge where the bit counter hits zero.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        scr_d      = scr_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    shift_d    = bin_i;
                    scr_d      = '0;
                    cnt_d      = CNT_W'(BIN_W);
                    ovf_pend_d = OVF_EN && (bin_i > MAX_BIN);
                    state_d    = CONV;
                end
            end
            CONV: begin
                scr_d   = scr_shift;
                shift_d = {shift_q[BIN_W-2:0], 1'b0};
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = ovf_pend_q ? {DIGITS{4'h9}} : scr_shift;
                    ovf_d   = ovf_pend_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = (state_q == CONV);
    assign done_o = done_q;
    assign ovf_o  = ovf_q;
    assign bcd_o  = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomised scoreboard bench for bin_to_bcd_seq: stimulus pushes the
// decimal-arithmetic expectation at each accepting edge, a monitor pops
// and compares whenever done is seen.
module tb_bin_to_bcd_seq;

    localparam int BIN_W  = 14;
    localparam int DIGITS = 4;
    localparam int BCD_W  = 4 * DIGITS;

    logic             clk, rst_n, start, busy, done, ovf;
    logic [BIN_W-1:0] bin;
    logic [BCD_W-1:0] bcd;

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .bin_i(bin),
        .busy_o(busy), .done_o(done), .ovf_o(ovf), .bcd_o(bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int done_cnt = 0;
    int push_cnt = 0;
    logic [BCD_W:0] exp_q[$];     // {ovf, bcd}
    int done_cyc[$];

    always @(posedge clk) cyc++;

    // Reference: plain decimal digit extraction, saturating to all-9s.
    function automatic logic [BCD_W:0] ref_model(int v);
        logic [BCD_W:0] r;
        int maxv, t;
        maxv = 1;
        for (int i = 0; i < DIGITS; i++) maxv = maxv * 10;
        maxv = maxv - 1;
        r = '0;
        if (v > maxv) begin
            r[BCD_W] = 1'b1;
            for (int d = 0; d < DIGITS; d++) r[4*d +: 4] = 4'h9;
        end else begin
            t = v;
            for (int d = 0; d < DIGITS; d++) begin
                r[4*d +: 4] = 4'(t % 10);
                t = t / 10;
            end
        end
        return r;
    endfunction

    task automatic check(string name, int act, int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: scoreboard pop on done, single-cycle done, output hold.
    initial begin
        logic [BCD_W:0] e;
        logic [BCD_W-1:0] last_bcd;
        logic last_ovf, done_prev;
        last_bcd = '0; last_ovf = 1'b0; done_prev = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                last_bcd = bcd; last_ovf = ovf; done_prev = 1'b0;
            end else if (done) begin
                done_cnt++;
                done_cyc.push_back(cyc);
                check("done_single_cycle", int'(done_prev), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("bcd", int'(bcd), int'(e[BCD_W-1:0]));
                    check("ovf", int'(ovf), int'(e[BCD_W]));
                end
                last_bcd = bcd; last_ovf = ovf; done_prev = 1'b1;
            end else begin
                if (bcd != last_bcd || ovf != last_ovf)
                    check("hold_between_dones", int'({ovf, bcd}), int'({last_ovf, last_bcd}));
                done_prev = 1'b0;
            end
        end
    end

    // Wait (bounded) for IDLE at a falling edge.
    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) check("idle_timeout", 1, 0);
    endtask

    // One conversion with latency and busy-length checks; optional stray
    // start pulse (bin=500) a few cycles in, which must be ignored.
    task automatic conv(int v, bit stray);
        int lat, nb;
        wait_idle();
        start = 1'b1; bin = BIN_W'(v);
        exp_q.push_back(ref_model(v)); push_cnt++;
        @(posedge clk); #1;
        start = 1'b0; bin = BIN_W'($urandom);
        lat = 0; nb = 0;
        while (!done && lat < 40) begin
            if (busy) nb++;
            if (stray && lat == 5) begin start = 1'b1; bin = BIN_W'(500); end
            else start = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check("latency", lat, BIN_W);
        check("busy_cycles", nb, BIN_W);
    endtask

    initial begin
        int dc0;
        int vals[4];
        int i;
        start = 1'b0; bin = '0; rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_bcd", int'(bcd), 0);
        rst_n = 1'b1;

        conv(0, 0);
        conv(1234, 0);
        conv(9999, 0);
        conv(16383, 0);
        conv(7, 0);
        conv(10000, 0);

        // Stray start during conversion is ignored: one done only.
        dc0 = done_cnt;
        conv(42, 1);
        repeat (20) @(negedge clk);
        check("stray_start_dones", done_cnt - dc0, 1);
        check("stray_start_bcd", int'(bcd), 16'h0042);

        // Reset mid-conversion aborts the in-flight result.
        conv(1234, 0);
        wait_idle();
        start = 1'b1; bin = BIN_W'(8765);
        @(posedge clk); #1; start = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_bcd", int'(bcd), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        dc0 = done_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check("abort_no_done", done_cnt - dc0, 0);
        conv(8765, 0);

        // Back-to-back with start held high.
        vals = '{9, 10, 99, 100};
        wait_idle();
        done_cyc.delete();
        i = 0;
        start = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (!busy) begin
                if (i < 4) begin
                    bin = BIN_W'(vals[i]);
                    exp_q.push_back(ref_model(vals[i])); push_cnt++;
                    i++;
                end else begin
                    start = 1'b0;
                    break;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("b2b_done_count", done_cyc.size(), 4);
        if (done_cyc.size() == 4)
            for (int k = 1; k < 4; k++)
                check("b2b_spacing", done_cyc[k] - done_cyc[k-1], BIN_W + 1);

        // Randomised conversions, including the overflow range.
        for (int k = 0; k < 30; k++) conv(int'($urandom_range(0, (1 << BIN_W) - 1)), 0);

        repeat (20) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        check("total_dones", done_cnt, push_cnt);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. It sits directly upstream of the per-digit 7-segment decoders. It turns a binary value (switches, counter, ALU result) into packed BCD digits, one 4-bit nibble per decoder. The BCD output is held stable between conversions, so the decoders never see intermediate values.

Parameters:
BIN_W, 14, width of binary input; conversion takes BIN_W cycles
DIGITS, 4, number of BCD digits produced; max representable = 10^DIGITS - 1

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request conversion of bin; sampled on rising clk
bin  input  BIN_W  unsigned binary value, sampled only on the accepting edge
busy  output  1  high while a conversion is in progress
done  output  1  single-cycle pulse when bcd/ovf are updated
ovf  output  1  high if the last accepted bin exceeded 10^DIGITS-1; held until next done
bcd  output  4*DIGITS  packed digits; [3:0] = ones, [7:4] = tens, ...; each nibble 0..9; held between dones

Behaviour:
- Clocking and reset:
  - One clock domain.
  - Reset is asynchronous and active-low, acting immediately on rst_n=0.
  - Reset values: busy=0, done=0, ovf=0, bcd=0, FSM=IDLE, working registers=0.
- FSM has two states, IDLE and CONV.
- IDLE:
  - On an edge with start=1, the block accepts. It latches bin into a shift register, clears the BCD scratch register, loads the bit counter with BIN_W, and goes to CONV.
  - On that same edge it computes ovf_pending = (bin > 10^DIGITS-1). The comparison uses a BIN_W-wide constant; if 10^DIGITS-1 >= 2^BIN_W, ovf_pending is always 0.
- CONV, each edge:
  - First, every scratch digit >= 5 gets +3 added.
  - Then {scratch, shift_reg} shifts left by 1, with the shift_reg MSB entering scratch bit 0.
  - The counter decrements by 1.
  - The edge on which the counter reaches 0 completes the conversion:
    - bcd <= scratch result, or all nibbles = 4'h9 if ovf_pending.
    - ovf <= ovf_pending.
    - done <= 1 for exactly one cycle.
    - FSM -> IDLE, busy <= 0.
- Latency: the start edge is E0; bcd, ovf and done update at edge E_BIN_W. done is visible in the cycle after E_BIN_W.
- busy:
  - Rises at E0 and falls at E_BIN_W.
  - busy = 1 exactly when FSM = CONV, so it is high for BIN_W cycles.
- start while busy=1 is ignored, with no queueing. bin changes during CONV have no effect.
- Back-to-back: start=1 in the cycle done=1 is accepted, since FSM is already IDLE. Maximum throughput is one result per BIN_W+1 cycles.
- bcd and ovf change only at the completion edge or on reset. They never show partial scratch values.
- Reset mid-conversion aborts:
  - The in-flight result is discarded; no done is produced.
  - bcd returns to 0.
- The scratch register is 4*DIGITS bits wide. When ovf_pending=0, no carry out of the top digit can occur.
- Corner cases:
  - bin=0 yields bcd=0 and done after BIN_W cycles.
  - Conversion time is constant and independent of the value.

Test Plan:
- Reset, then start with bin=0 -> busy high 14 cycles; done pulses once at 14 cycles after the start edge; bcd=16'h0000; ovf=0.
- bin=1234, then bin=9999 -> bcd=16'h1234 then 16'h9999, each with ovf=0; bcd holds 1234 throughout the second conversion until its done.
- bin=16383 (14'h3FFF) -> bcd=16'h9999, ovf=1. Following bin=7 -> bcd=16'h0007, ovf clears to 0.
- start pulsed again 5 cycles into a conversion of 42 with bin=500 -> ignored; a single done; bcd=16'h0042.
- rst_n driven low 6 cycles into a conversion of 8765 (prior bcd=16'h1234) -> bcd, busy and done immediately 0; no done pulse after release; a fresh start of 8765 gives 16'h8765.
- Back-to-back: start held high continuously with bin stepping 9,10,99,100 -> dones spaced exactly 15 cycles apart; bcd=0009, 0010, 0099, 0100.
